// File: rtl/trace_collector_arbiter_pkg.sv
// trace_collector_arbiter_pkg: trace record layout and tracker source ordering shared by the collector and its users
package trace_collector_arbiter_pkg;
  typedef struct packed {
    logic [31:0] cycle;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [3:0]  stage;
    logic [27:0] info;
  } trace_output;
  localparam int TRACE_W = $bits(trace_output);
  typedef enum logic [1:0] {TRACE_SRC_IF, TRACE_SRC_ID, TRACE_SRC_EX, TRACE_SRC_WB} trace_src_e;
  localparam int TRACE_N_SRC = 4;
endpackage

// File: rtl/trace_collector_arbiter_if.sv
// trace_collector_arbiter_if: tracker-side inputs, sink handshake and statistics of the collector
interface trace_collector_arbiter_if
  import trace_collector_arbiter_pkg::*;
#(
  parameter int N_SRC = TRACE_N_SRC,
  parameter int TRACE_WIDTH = TRACE_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH = 16
);
  logic [N_SRC-1:0] src_ready;
  logic [N_SRC*TRACE_WIDTH-1:0] src_data;
  logic trace_valid;
  logic [TRACE_WIDTH-1:0] trace_data;
  logic trace_ack;
  logic clr_stats;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [CNT_WIDTH-1:0] drop_count;
  logic overflow;
  modport master (
    output src_ready, src_data, trace_ack, clr_stats,
    input  trace_valid, trace_data, fifo_level, drop_count, overflow
  );
  modport slave (
    input  src_ready, src_data, trace_ack, clr_stats,
    output trace_valid, trace_data, fifo_level, drop_count, overflow
  );
endinterface

// File: rtl/trace_collector_arbiter_trace_fifo.sv
// trace_fifo: show-ahead synchronous FIFO; head reads as zero while empty
module trace_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop) count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/trace_collector_arbiter.sv
// trace_collector_arbiter: captures tracker records on ready rising edges and merges them round-robin into one FIFO stream
module trace_collector_arbiter
  import trace_collector_arbiter_pkg::*;
#(
  parameter int N_SRC = TRACE_N_SRC,
  parameter int TRACE_WIDTH = TRACE_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  trace_collector_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_SRC);
  logic [N_SRC-1:0] prev_ready, hold_valid, rise, gnt, drop;
  logic [TRACE_WIDTH-1:0] hold [N_SRC];
  logic [IW-1:0] last_grant, gnt_idx;
  logic push, pop, full, empty;
  logic [3:0] n_drop;
  logic [CNT_WIDTH:0] drop_sum;
  assign rise = bus.src_ready & ~prev_ready;
  assign pop = ~empty & bus.trace_ack;
  assign bus.trace_valid = ~empty;
  always_comb begin
    push = 1'b0;
    gnt_idx = last_grant;
    for (int k = 1; k <= N_SRC; k++)
      if (!push && (~full | pop) && hold_valid[(int'(last_grant) + k) % N_SRC]) begin
        push = 1'b1;
        gnt_idx = IW'((int'(last_grant) + k) % N_SRC);
      end
  end
  assign gnt = push ? {{(N_SRC-1){1'b0}}, 1'b1} << gnt_idx : '0;
  // an occupied slot only accepts a new record when it is drained in the same cycle
  assign drop = rise & hold_valid & ~gnt;
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_SRC; i++) n_drop = n_drop + 4'(drop[i]);
  end
  assign drop_sum = {1'b0, bus.drop_count} + (CNT_WIDTH+1)'(n_drop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev_ready <= '0;
      hold_valid <= '0;
      last_grant <= IW'(N_SRC - 1);
      bus.drop_count <= '0;
      bus.overflow <= 1'b0;
    end else begin
      prev_ready <= bus.src_ready;
      hold_valid <= (hold_valid & ~gnt) | (rise & ~drop);
      if (push) last_grant <= gnt_idx;
      if (bus.clr_stats) begin
        bus.drop_count <= '0;
        bus.overflow <= 1'b0;
      end else if (|drop) begin
        bus.drop_count <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
        bus.overflow <= 1'b1;
      end
    end
  always_ff @(posedge clk)
    for (int i = 0; i < N_SRC; i++)
      if (rise[i] & ~drop[i]) hold[i] <= bus.src_data[i*TRACE_WIDTH +: TRACE_WIDTH];
  trace_fifo #(.WIDTH(TRACE_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(hold[gnt_idx]),
    .dout(bus.trace_data),
    .count(bus.fifo_level),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_trace_collector_arbiter.sv
// tb_trace_collector_arbiter: directed vectors for capture, round-robin order, full/drop handling and reset
module tb_trace_collector_arbiter;
  import trace_collector_arbiter_pkg::*;
  localparam int N = 4, W = TRACE_W, D = 8, C = 16;
  logic clk = 1'b0, rst = 1'b1;
  int n_cmp = 0, n_err = 0, seen;
  logic [W-1:0] got;
  int ord [4] = '{1, 2, 3, 0};
  always #5 clk = ~clk;
  trace_collector_arbiter_if #(.N_SRC(N), .TRACE_WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(C)) bus ();
  trace_collector_arbiter #(.N_SRC(N), .TRACE_WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(C)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] mk(int s, int n);
    trace_output r;
    r.cycle = 32'(n);
    r.pc = {32'hA5A5_A5A5, 32'(s)};
    r.instr = 32'h5A5A_0000 | 32'(n);
    r.stage = 4'(s);
    r.info = 28'hA5A5A5A;
    return r;
  endfunction
  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic fire(logic [N-1:0] mask, int n);
    for (int s = 0; s < N; s++)
      if (mask[s]) bus.src_data[s*W +: W] = mk(s, n);
    bus.src_ready = mask;
    step();
    bus.src_ready = '0;
  endtask
  task automatic check_zero(string tag);
    check({tag, "_valid"}, W'(bus.trace_valid), '0);
    check({tag, "_data"}, bus.trace_data, '0);
    check({tag, "_level"}, W'(bus.fifo_level), '0);
    check({tag, "_drop"}, W'(bus.drop_count), '0);
    check({tag, "_ovf"}, W'(bus.overflow), '0);
  endtask
  initial begin
    bus.src_ready = '0;
    bus.src_data = '0;
    bus.trace_ack = 1'b0;
    bus.clr_stats = 1'b0;
    step(2);
    check_zero("rst");
    rst = 1'b0;
    bus.trace_ack = 1'b1;
    for (int b = 1; b <= 2; b++) begin
      fire(4'hF, b);
      check("rr_lat", W'(bus.trace_valid), W'(0));
      step();
      for (int k = 0; k < 4; k++) begin
        check("rr_valid", W'(bus.trace_valid), W'(1));
        check("rr_data", bus.trace_data, mk(k, b));
        step();
      end
      check("rr_empty", W'(bus.fifo_level), W'(0));
    end
    fire(4'b0001, 5);
    check("one_lat", W'(bus.trace_valid), W'(0));
    step();
    check("one_valid", W'(bus.trace_valid), W'(1));
    check("one_data", bus.trace_data, mk(0, 5));
    check("one_level", W'(bus.fifo_level), W'(1));
    step();
    check("one_drain", W'(bus.fifo_level), W'(0));
    bus.trace_ack = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      fire(4'hF, b);
      step(4);
    end
    check("full_level", W'(bus.fifo_level), W'(8));
    check("full_drop0", W'(bus.drop_count), W'(0));
    check("full_ovf0", W'(bus.overflow), W'(0));
    fire(4'b0010, 99);
    step();
    check("drop_cnt", W'(bus.drop_count), W'(1));
    check("drop_ovf", W'(bus.overflow), W'(1));
    bus.trace_ack = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("drain_valid", W'(bus.trace_valid), W'(1));
      check("drain_data", bus.trace_data, mk(ord[k%4], k/4 + 1));
      if (k <= 4) check("pushpop_level", W'(bus.fifo_level), W'(8));
      step();
    end
    check("drain_empty", W'(bus.fifo_level), W'(0));
    check("pushpop_nodrop", W'(bus.drop_count), W'(1));
    bus.clr_stats = 1'b1;
    step();
    bus.clr_stats = 1'b0;
    check("clr_drop", W'(bus.drop_count), W'(0));
    check("clr_ovf", W'(bus.overflow), W'(0));
    for (int b = 7; b <= 8; b++) begin
      bus.src_data[int'(TRACE_SRC_EX)*W +: W] = mk(int'(TRACE_SRC_EX), b);
      bus.src_ready = 4'b0100;
      seen = 0;
      got = '0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (bus.trace_valid) begin
          seen++;
          got = bus.trace_data;
        end
      end
      check("held_count", W'(seen), W'(1));
      check("held_data", got, mk(int'(TRACE_SRC_EX), b));
      bus.src_ready = '0;
      step();
    end
    bus.trace_ack = 1'b0;
    fire(4'hF, 1);
    step(4);
    fire(4'hF, 2);
    step();
    check("mid_level", W'(bus.fifo_level), W'(5));
    bus.src_data[3*W +: W] = mk(3, 50);
    bus.src_ready = 4'b1000;
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    step(2);
    rst = 1'b0;
    bus.trace_ack = 1'b1;
    step();
    check("post_lat", W'(bus.trace_valid), W'(0));
    step();
    check("post_valid", W'(bus.trace_valid), W'(1));
    check("post_data", bus.trace_data, mk(3, 50));
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.trace_valid) seen++;
    end
    check("post_extra", W'(seen), W'(0));
    check("post_drop", W'(bus.drop_count), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
